// File: rtl/prog_loader.sv
// Instruction-memory loader: receives a count byte N followed by 4*N bytes.
// It packs each group of 4 bytes MSB-first into one word, writes the words at
// incrementing addresses, and holds the CPU in reset until the load finishes.
module prog_loader #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_COUNT = 3'd1,
        S_GET_BYTES = 3'd2,
        S_WRITE     = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W:0]   n_total_s;

    // A count byte of zero stands for a full memory of 2**ADDR_W words.
    assign n_total_s = (count_q == {ADDR_W{1'b0}}) ? {1'b1, {ADDR_W{1'b0}}}
                                                   : {1'b0, count_q};

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign done         = done_q;
    assign err_timeout  = err_q;
    assign words_loaded = words_q;

    // Next-state logic and state-decoded handshake/strobe outputs.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        byte_idx_d = byte_idx_q;
        words_d    = words_q;
        done_d     = done_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        rx_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                cpu_hold = 1'b0;
                if (start) begin
                    state_d = S_GET_COUNT;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = {(ADDR_W+1){1'b0}};
                    tmo_d   = {TMO_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GET_COUNT: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    count_d    = ADDR_W'(rx_data);
                    addr_d     = {ADDR_W{1'b0}};
                    byte_idx_d = 2'd0;
                    tmo_d      = {TMO_W{1'b0}};
                    state_d    = S_GET_BYTES;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_GET_BYTES: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    wdata_d    = {wdata_q[23:0], rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    tmo_d      = {TMO_W{1'b0}};
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_GET_BYTES;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort drops the partially assembled word.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                words_d = words_q + (ADDR_W+1)'(1);
                addr_d  = addr_q + ADDR_W'(1);
                tmo_d   = {TMO_W{1'b0}};
                if (words_q + (ADDR_W+1)'(1) == n_total_s) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_GET_BYTES;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            count_q    <= {ADDR_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= 32'd0;
            byte_idx_q <= 2'd0;
            words_q    <= {(ADDR_W+1){1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= {TMO_W{1'b0}};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            byte_idx_q <= byte_idx_d;
            words_q    <= words_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized bench for prog_loader, checked against a behavioural
// model of the byte-stream format (word = b0*2^24 + b1*2^16 + b2*2^8 + b3).
module tb_prog_loader;
    localparam int AW  = 8;
    localparam int TMO = 100;

    logic          CLK = 1'b0;
    logic          RESET, start, rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready, mem_we, cpu_hold, busy, done, err_timeout;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   words_loaded;

    prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int done_rise_cyc = -1;
    int err_rise_cyc = -1;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    logic [7:0]    stream_q[$];
    logic [AW-1:0] we_addr_q[$];
    logic [31:0]   we_data_q[$];
    int            we_cyc_q[$];
    int            exp_hs_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every write strobe and the cycle where done / err_timeout rise.
    always @(negedge CLK) begin
        if (mem_we === 1'b1) begin
            we_addr_q.push_back(mem_addr);
            we_data_q.push_back(mem_wdata);
            we_cyc_q.push_back(cyc);
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
        if (err_timeout === 1'b1 && prev_err !== 1'b1) err_rise_cyc = cyc;
        prev_done = done;
        prev_err  = err_timeout;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        we_cyc_q.delete();
        exp_hs_q.delete();
        done_rise_cyc = -1;
        err_rise_cyc  = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waitc;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waitc    = 0;
        while (rx_ready !== 1'b1 && waitc < 300) begin
            tick();
            waitc++;
        end
        if (waitc >= 300) check("rx_ready_wait", 64'(waitc), 64'd0);
        tick();
        last_hs_cyc = cyc;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Full load of stream_q; optional start pulse after stream byte start_at.
    task automatic run_load(input string tag, input int gapmax, input int start_at);
        int n, t, lim;
        logic [31:0] w;
        clear_mon();
        n = (stream_q[0] == 8'd0) ? 256 : int'(stream_q[0]);
        pulse_start();
        check({tag, "_busy_on"}, {62'd0, busy, cpu_hold}, 64'd3);
        check({tag, "_clr"}, {done, err_timeout, words_loaded}, 64'd0);
        for (int i = 0; i < stream_q.size(); i++) begin
            send_byte(stream_q[i], (gapmax > 0) ? int'($urandom_range(gapmax, 1)) : 0);
            if (i >= 1 && ((i - 1) % 4) == 3) exp_hs_q.push_back(last_hs_cyc);
            if (i == start_at) begin
                pulse_start();
                check({tag, "_start_ignored"}, {62'd0, busy, rx_ready}, 64'd3);
            end
        end
        t = 0;
        while (done !== 1'b1 && err_timeout !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        tick();
        check({tag, "_nwrites"}, 64'(we_addr_q.size()), 64'(n));
        lim = (we_addr_q.size() < n) ? we_addr_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            w = 32'(stream_q[1+4*i]) * 32'd16777216 + 32'(stream_q[2+4*i]) * 32'd65536
              + 32'(stream_q[3+4*i]) * 32'd256 + 32'(stream_q[4+4*i]);
            check({tag, "_addr"}, 64'(we_addr_q[i]), 64'(i % 256));
            check({tag, "_data"}, 64'(we_data_q[i]), 64'(w));
            check({tag, "_we_lat"}, 64'(we_cyc_q[i]), 64'(exp_hs_q[i]));
        end
        if (lim > 0) check({tag, "_done_lat"}, 64'(done_rise_cyc), 64'(we_cyc_q[lim-1] + 2));
        check({tag, "_flags"}, {60'd0, done, err_timeout, cpu_hold, busy}, 64'h8);
        check({tag, "_words"}, 64'(words_loaded), 64'(n));
        check({tag, "_addr_end"}, 64'(mem_addr), 64'(n % 256));
    endtask

    task automatic make_random_stream(input int n);
        stream_q.delete();
        stream_q.push_back(8'(n));
        for (int i = 0; i < 4 * ((n == 0) ? 256 : n); i++) stream_q.push_back(8'($urandom));
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) tick();
        check("reset_outputs", {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy,
                                done, err_timeout, words_loaded}, 64'd0);
        RESET = 1'b0;
        repeat (2) tick();

        // Fixed two-word load, no gaps.
        stream_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h08, 8'h00, 8'h00, 8'h00};
        run_load("t1", 0, -1);
        check("t1_word0", 64'(we_data_q.size() > 0 ? we_data_q[0] : 32'hx), 64'h00112233);

        // Same stream with random 1-20 cycle gaps on rx_valid.
        run_load("t2", 20, -1);

        // Random streams with gaps, plus a start pulse in GET_BYTES.
        make_random_stream(int'($urandom_range(7, 1)));
        run_load("t6", 5, 2);
        make_random_stream(int'($urandom_range(5, 1)));
        run_load("trand", 12, -1);

        // N=0: full 256-word load, address wraps to 0.
        make_random_stream(0);
        run_load("t3", 0, -1);

        // Timeout: N=2 but only 6 data bytes arrive.
        make_random_stream(2);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream_q[i], int'($urandom_range(3, 0)));
        for (int t = 0; t < 300 && err_timeout !== 1'b1; t++) tick();
        tick();
        check("t4_err_lat", 64'(err_rise_cyc), 64'(last_hs_cyc + TMO));
        check("t4_nwrites", 64'(we_data_q.size()), 64'd1);
        check("t4_word0", 64'(we_data_q.size() > 0 ? we_data_q[0] : 32'hx),
              64'({stream_q[1], stream_q[2], stream_q[3], stream_q[4]}));
        check("t4_flags", {60'd0, done, err_timeout, cpu_hold, busy}, 64'h4);
        check("t4_words", 64'(words_loaded), 64'd1);

        // Reset in the middle of the second word.
        make_random_stream(2);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream_q[i], 0);
        RESET = 1'b1;
        tick();
        check("t5_reset_outputs", {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy,
                                   done, err_timeout, words_loaded}, 64'd0);
        RESET = 1'b0;
        repeat (10) tick();
        check("t5_nwrites", 64'(we_data_q.size()), 64'd1);
        make_random_stream(1);
        run_load("t5_reload", 3, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
